pci_uart_resp: RTL and testbench

- Return path of the UART-to-PCI bridge. It snoops the local PCI bus and captures the data of every completed read data phase.
- Captured words go into a small FIFO. Each word is serialized over an 8N1 UART transmit line, 4 bytes per word, least-significant byte first.
- Sits beside the UART receiver and PCI command generator, on the same bus as the PCI target, and clocked by the same bus clock.

---
 rtl/pci_uart_pkg.sv | 22 ++
 rtl/uart_tx_byte.sv | 80 ++++++++
 rtl/pci_uart_resp.sv | 189 ++++++++++++++++++
 tb/tb_pci_uart_resp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_uart_pkg.sv
// Shared constants and state encodings for the PCI read-data to UART return path.
package pci_uart_pkg;

   localparam logic [3:0] PCI_CMD_MEMRD = 4'b0110;
   localparam logic [3:0] PCI_CMD_IORD  = 4'b0010;
   localparam logic [7:0] UART_HDR_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_LOAD  = 3'd1,
      TX_START = 3'd2,
      TX_DATA  = 3'd3,
      TX_STOP  = 3'd4
   } tx_state_t;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_LOAD = 2'd1,
      SEQ_SEND = 2'd2
   } seq_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a ready/valid byte interface.
// The tx register follows the bit state one clock later, so every bit keeps its full width.
module uart_tx_byte
   import pci_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       done,
   output logic       tx
);

   localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

   tx_state_t   st_r;
   tx_state_t   st_nxt_s;
   logic [15:0] cnt_r;
   logic [2:0]  bit_r;
   logic [7:0]  shreg_r;
   logic        tx_r;
   logic        bit_end_s;

   // Next-state decode for the bit-level FSM.
   always_comb begin
      st_nxt_s  = st_r;
      bit_end_s = (cnt_r == CNT_LAST);
      case (st_r)
         TX_IDLE: begin
            if (valid) st_nxt_s = TX_START;
            else       st_nxt_s = TX_IDLE;
         end
         TX_START: begin
            if (bit_end_s) st_nxt_s = TX_DATA;
            else           st_nxt_s = TX_START;
         end
         TX_DATA: begin
            if (bit_end_s && (bit_r == 3'd7)) st_nxt_s = TX_STOP;
            else                              st_nxt_s = TX_DATA;
         end
         TX_STOP: begin
            if (bit_end_s) st_nxt_s = TX_IDLE;
            else           st_nxt_s = TX_STOP;
         end
         default: st_nxt_s = TX_IDLE;
      endcase
   end

   // State, baud counter, bit index, shifter and line register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         st_r    <= TX_IDLE;
         cnt_r   <= 16'd0;
         bit_r   <= 3'd0;
         shreg_r <= 8'h00;
         tx_r    <= 1'b1;
      end else begin
         st_r <= st_nxt_s;
         if ((st_r == TX_IDLE) || bit_end_s) cnt_r <= 16'd0;
         else                                cnt_r <= cnt_r + 16'd1;
         if (st_r != TX_DATA)  bit_r <= 3'd0;
         else if (bit_end_s)   bit_r <= bit_r + 3'd1;
         if ((st_r == TX_IDLE) && valid)            shreg_r <= data;
         else if ((st_r == TX_DATA) && bit_end_s)   shreg_r <= {1'b0, shreg_r[7:1]};
         case (st_r)
            TX_START: tx_r <= 1'b0;
            TX_DATA:  tx_r <= shreg_r[0];
            default:  tx_r <= 1'b1;
         endcase
      end
   end

   assign ready = (st_r == TX_IDLE);
   assign done  = (st_r == TX_STOP) && bit_end_s;
   assign tx    = tx_r;

endmodule

// File: rtl/pci_uart_resp.sv
// PCI read-data snooper, word FIFO and byte sequencer feeding an 8N1 UART transmitter.
// Build option PCI_UART_HDR_EN prefixes every word with a header byte (5 bytes per word).
module pci_uart_resp
   import pci_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_AW      = 2
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic        frame_,
   input  logic        irdy_,
   input  logic        trdy_,
   input  logic        devsel_,
   input  logic [31:0] ad_bus,
   input  logic [3:0]  cbe,
   output logic        txOUT,
   output logic        txBusyOUT,
   output logic        ovfOUT
);

   localparam int               DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] CNT_ZERO = (FIFO_AW + 1)'(0);
   localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
`ifdef PCI_UART_HDR_EN
   localparam logic [2:0] LAST_IDX = 3'd4;
`else
   localparam logic [2:0] LAST_IDX = 3'd3;
`endif

   logic                frame_d_r;
   logic                phase_act_r;
   logic [3:0]          cmd_r;
   logic                rd_act_s;
   logic                push_req_s;
   logic                push_s;
   logic                pop_s;
   logic                full_s;
   logic                drop_s;
   logic [31:0]         mem_r [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_r;
   logic [FIFO_AW-1:0]  rd_ptr_r;
   logic [FIFO_AW:0]    cnt_r;
   logic [FIFO_AW:0]    cnt_nxt_s;
   seq_state_t          seq_r;
   seq_state_t          seq_nxt_s;
   logic [2:0]          idx_r;
   logic [31:0]         hold_r;
   logic [7:0]          byte_s;
   logic                byte_valid_s;
   logic                byte_ready_s;
   logic                byte_done_s;
   logic                busy_r;
   logic                ovf_r;

   // Transaction tracker: latch the command on the FRAME# falling edge.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         frame_d_r   <= 1'b1;
         phase_act_r <= 1'b0;
         cmd_r       <= 4'h0;
      end else begin
         frame_d_r <= frame_;
         if (frame_d_r && !frame_) begin
            cmd_r       <= cbe;
            phase_act_r <= 1'b1;
         end else if (frame_ && irdy_) begin
            phase_act_r <= 1'b0;
         end
      end
   end

   // Capture qualification and FIFO bookkeeping; a simultaneous pop frees room for the push.
   always_comb begin
      rd_act_s   = phase_act_r && ((cmd_r == PCI_CMD_MEMRD) || (cmd_r == PCI_CMD_IORD));
      push_req_s = rd_act_s && !irdy_ && !trdy_ && !devsel_;
      pop_s      = (seq_r == SEQ_IDLE) && (cnt_r != CNT_ZERO);
      full_s     = (cnt_r == CNT_FULL);
      push_s     = push_req_s && (!full_s || pop_s);
      drop_s     = push_req_s && full_s && !pop_s;
      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
         2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Word FIFO storage and pointers.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= 32'h0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= CNT_ZERO;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= ad_bus;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
         cnt_r <= cnt_nxt_s;
      end
   end

   // Byte sequencer next-state decode.
   always_comb begin
      seq_nxt_s    = seq_r;
      byte_valid_s = 1'b0;
      case (seq_r)
         SEQ_IDLE: begin
            if (cnt_r != CNT_ZERO) seq_nxt_s = SEQ_LOAD;
            else                   seq_nxt_s = SEQ_IDLE;
         end
         SEQ_LOAD: begin
            byte_valid_s = 1'b1;
            if (byte_ready_s) seq_nxt_s = SEQ_SEND;
            else              seq_nxt_s = SEQ_LOAD;
         end
         SEQ_SEND: begin
            if (byte_done_s) begin
               if (idx_r == LAST_IDX) seq_nxt_s = SEQ_IDLE;
               else                   seq_nxt_s = SEQ_LOAD;
            end else begin
               seq_nxt_s = SEQ_SEND;
            end
         end
         default: seq_nxt_s = SEQ_IDLE;
      endcase
   end

   // Byte selection from the holding register.
   always_comb begin
      byte_s = 8'h00;
      case (idx_r)
`ifdef PCI_UART_HDR_EN
         3'd0:    byte_s = UART_HDR_BYTE;
         3'd1:    byte_s = hold_r[7:0];
         3'd2:    byte_s = hold_r[15:8];
         3'd3:    byte_s = hold_r[23:16];
         3'd4:    byte_s = hold_r[31:24];
`else
         3'd0:    byte_s = hold_r[7:0];
         3'd1:    byte_s = hold_r[15:8];
         3'd2:    byte_s = hold_r[23:16];
         3'd3:    byte_s = hold_r[31:24];
`endif
         default: byte_s = 8'h00;
      endcase
   end

   // Sequencer state, holding register, byte index and status outputs.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         seq_r  <= SEQ_IDLE;
         idx_r  <= 3'd0;
         hold_r <= 32'h0;
         busy_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         seq_r <= seq_nxt_s;
         if (pop_s) begin
            hold_r <= mem_r[rd_ptr_r];
            idx_r  <= 3'd0;
         end else if ((seq_r == SEQ_SEND) && byte_done_s && (idx_r != LAST_IDX)) begin
            idx_r <= idx_r + 3'd1;
         end
         busy_r <= (cnt_nxt_s != CNT_ZERO) || (seq_nxt_s != SEQ_IDLE);
         ovf_r  <= ovf_r || drop_s;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk   (clk),
      .rst_  (rst_),
      .valid (byte_valid_s),
      .data  (byte_s),
      .ready (byte_ready_s),
      .done  (byte_done_s),
      .tx    (txOUT)
   );

   assign txBusyOUT = busy_r;
   assign ovfOUT    = ovf_r;

endmodule

// File: tb/tb_pci_uart_resp.sv
// Directed bench for pci_uart_resp: PCI bus stimulus and a UART line decoder with timing checks.
module tb_pci_uart_resp;

   localparam int CPB = 8;
`ifdef PCI_UART_HDR_EN
   localparam int BPW = 5;
`else
   localparam int BPW = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        frame_ = 1'b1, irdy_ = 1'b1, trdy_ = 1'b1, devsel_ = 1'b1;
   logic [31:0] ad_bus = 32'h0;
   logic [3:0]  cbe = 4'h0;
   logic        txOUT, txBusyOUT, ovfOUT;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  byte_q[$];
   int          start_q[$];
   logic        stop_q[$];
   logic [31:0] exp_w [8];

   pci_uart_resp #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
      .clk(clk), .rst_(rst_), .frame_(frame_), .irdy_(irdy_), .trdy_(trdy_),
      .devsel_(devsel_), .ad_bus(ad_bus), .cbe(cbe),
      .txOUT(txOUT), .txBusyOUT(txBusyOUT), .ovfOUT(ovfOUT)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // UART line decoder: start edge cycle, data bits at mid-bit, stop bit.
   initial begin : rx_mon
      logic       prev;
      int         s;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev && !txOUT) begin
            s = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (CPB) @(negedge clk);
               b[k] = txOUT;
            end
            repeat (CPB) @(negedge clk);
            byte_q.push_back(b);
            start_q.push_back(s);
            stop_q.push_back(txOUT);
         end
         prev = txOUT;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [31:0] w, input int b);
`ifdef PCI_UART_HDR_EN
      if (b == 0) return 8'hA5;
      return w[8*(b-1) +: 8];
`else
      return w[8*b +: 8];
`endif
   endfunction

   task automatic drive(input logic fr, input logic ir, input logic tr, input logic dv,
                        input logic [3:0] c, input logic [31:0] a);
      @(negedge clk);
      frame_ = fr; irdy_ = ir; trdy_ = tr; devsel_ = dv; cbe = c; ad_bus = a;
   endtask

   task automatic bus_idle();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h0);
   endtask

   task automatic wait_bytes(input int n);
      int k;
      k = 0;
      while ((byte_q.size() < n) && (k < n * (10 * CPB + 2) + 20 * CPB)) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic clear_rx();
      byte_q.delete();
      start_q.delete();
      stop_q.delete();
   endtask

   // Compare nw expected words: byte values, start-edge cycles and stop bits.
   task automatic verify_words(input string tag, input int nw, input int first_start);
      int idx;
      int t;
      idx = 0;
      t = first_start;
      wait_bytes(nw * BPW);
      check_eq({tag, "_nbytes"}, 32'(byte_q.size()), 32'(nw * BPW));
      if (byte_q.size() >= nw * BPW) begin
         for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < BPW; b++) begin
               check_eq({tag, "_byte"}, 32'(byte_q[idx]), 32'(exp_byte(exp_w[w], b)));
               check_eq({tag, "_start"}, 32'(start_q[idx]), 32'(t));
               check_eq({tag, "_stop"}, 32'(stop_q[idx]), 32'd1);
               t = t + 10 * CPB + ((b == BPW - 1) ? 2 : 1);
               idx++;
            end
         end
      end
      repeat (12 * CPB) @(negedge clk);
      check_eq({tag, "_no_extra"}, 32'(byte_q.size()), 32'(nw * BPW));
      check_eq({tag, "_idle_busy"}, 32'(txBusyOUT), 32'd0);
      clear_rx();
   endtask

   // Address phase, one completed data phase; returns the capture cycle.
   task automatic single_read(input logic [3:0] cmd, input logic [31:0] data, output int cap);
      bus_idle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, cmd, 32'h1000_0000);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, data);
      cap = cyc + 1;
      bus_idle();
   endtask

   initial begin : main
      int cap;
      int tgt;
      int guard;
      logic seen_low, seen_busy;

      repeat (3) @(negedge clk);
      check_eq("rst_tx", 32'(txOUT), 32'd1);
      check_eq("rst_busy", 32'(txBusyOUT), 32'd0);
      check_eq("rst_ovf", 32'(ovfOUT), 32'd0);
      rst_ = 1'b1;
      repeat (3) @(negedge clk);

      // Single memory read.
      single_read(4'h6, 32'h12345678, cap);
      repeat (3) @(negedge clk);
      check_eq("rd_busy", 32'(txBusyOUT), 32'd1);
      exp_w[0] = 32'h12345678;
      verify_words("rd1", 1, cap + 3);
      check_eq("rd1_ovf", 32'(ovfOUT), 32'd0);

      // I/O read of a second pattern (header build sends A5 first).
      single_read(4'h2, 32'hA1B2C3D4, cap);
      exp_w[0] = 32'hA1B2C3D4;
      verify_words("iord", 1, cap + 3);

      // Memory write, and a read without DEVSEL#: both ignored.
      seen_low = 1'b0;
      seen_busy = 1'b0;
      bus_idle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 32'h2000_0000);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'hCAFE0001);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'hCAFE0002);
      bus_idle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 32'h3000_0000);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'hCAFE0003);
      bus_idle();
      for (int i = 0; i < 12 * CPB; i++) begin
         @(negedge clk);
         seen_low  = seen_low | ~txOUT;
         seen_busy = seen_busy | txBusyOUT;
      end
      check_eq("wr_tx_low", 32'(seen_low), 32'd0);
      check_eq("wr_busy", 32'(seen_busy), 32'd0);
      check_eq("wr_nbytes", 32'(byte_q.size()), 32'd0);

      // Wait states before the single completed data phase.
      bus_idle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 32'h4000_0000);
      repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'hBAD0BAD0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'hDEADBEEF);
      cap = cyc + 1;
      bus_idle();
      exp_w[0] = 32'hDEADBEEF;
      verify_words("wait", 1, cap + 3);

      // Six-phase burst into a four-deep FIFO: word 6 dropped.
      bus_idle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 32'h5000_0000);
      for (int i = 1; i <= 6; i++) begin
         drive((i == 6) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'(i));
         if (i == 1) cap = cyc + 1;
      end
      bus_idle();
      check_eq("burst_ovf", 32'(ovfOUT), 32'd1);
      for (int i = 0; i < 5; i++) exp_w[i] = 32'(i + 1);
      verify_words("burst", 5, cap + 3);
      check_eq("burst_ovf_sticky", 32'(ovfOUT), 32'd1);

      // Reset during the data bits of byte 2 (byte value 00, so the line is low).
      single_read(4'h6, 32'h5500AA33, cap);
      tgt = cap + 3 + 2 * (10 * CPB + 1) + 3 * CPB;
      guard = 0;
      while ((cyc < tgt) && (guard < 2000)) begin
         @(negedge clk);
         guard++;
      end
      check_eq("mid_reached", 32'(cyc), 32'(tgt));
      check_eq("mid_tx_low", 32'(txOUT), 32'd0);
      #2 rst_ = 1'b0;
      #1;
      check_eq("mid_rst_tx", 32'(txOUT), 32'd1);
      check_eq("mid_rst_ovf", 32'(ovfOUT), 32'd0);
      check_eq("mid_rst_busy", 32'(txBusyOUT), 32'd0);
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      repeat (14 * CPB) @(negedge clk);
      clear_rx();
      seen_low = 1'b0;
      for (int i = 0; i < 12 * CPB; i++) begin
         @(negedge clk);
         seen_low = seen_low | ~txOUT;
      end
      check_eq("post_rst_tx_low", 32'(seen_low), 32'd0);
      check_eq("post_rst_nbytes", 32'(byte_q.size()), 32'd0);
      check_eq("post_rst_ovf", 32'(ovfOUT), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
